alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, operand and result width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 req_a  input  32  operand a; bits [16i+15:16i] belong to requester i.
REQ-007 req_b  input  32  operand b; same packing as req_a.
REQ-008 req_ctrl  input  8  ALU opcode; bits [4i+3:4i] belong to requester i.
REQ-009 alu_a  output  16  operand a to the shared alu_control.
REQ-010 alu_b  output  16  operand b to the shared alu_control.
REQ-011 alu_ctrl  output  4  opcode to the shared alu_control.
REQ-012 alu_s  input  16  ALU result.
REQ-013 alu_zero  input  1  ALU zero flag.
REQ-014 alu_overflow  input  1  ALU overflow flag.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_id  output  1  index of the requester that owns the response.
REQ-017 rsp_s  output  16  registered result.
REQ-018 rsp_zero  output  1  registered zero flag.
REQ-019 rsp_overflow  output  1  registered overflow flag.
REQ-020 rsp_ready  input  1  consumer accepts the response.

Function
REQ-021 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-022 In IDLE with any req_valid bit set, req_ready SHALL assert combinationally for exactly one granted requester.
REQ-023 Arbitration SHALL be round-robin: when both requesters are valid, the requester other than last_grant wins; when only one is valid, that requester wins.
REQ-024 On an IDLE cycle with a grant, the block SHALL latch the granted requester's a, b, ctrl and id into internal operand registers, update last_grant to the granted id, and move to EXEC.
REQ-025 alu_a, alu_b and alu_ctrl SHALL be driven from the operand registers at all times, never directly from req_*.
REQ-026 In EXEC, the block SHALL capture alu_s, alu_zero and alu_overflow into rsp_s, rsp_zero and rsp_overflow, set rsp_valid, and move to RESP.
REQ-027 In RESP, rsp_valid SHALL remain 1 and all rsp_* SHALL hold stable until a cycle with rsp_ready=1.
REQ-028 On that rsp_ready cycle, the block SHALL clear rsp_valid and return to IDLE.
REQ-029 Latency: for a grant in cycle N, rsp_valid SHALL first be 1 in cycle N+2; minimum issue interval is 3 cycles.
REQ-030 req_ready SHALL be 0 in EXEC and RESP; requests arriving there SHALL wait and not be lost, provided the requester holds req_valid.
REQ-031 A requester that drops req_valid before being granted SHALL NOT be served.
REQ-032 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-033 A response accept and a new request in the same cycle SHALL NOT be granted until the following cycle, when the FSM is back in IDLE.
REQ-034 The ALU result SHALL pass through unmodified; the block performs no arithmetic.

Reset
REQ-035 While rst=1: state=IDLE; last_grant=1, so requester 0 wins the first tie; req_ready=0; rsp_valid=0; rsp_id, rsp_s, rsp_zero, rsp_overflow=0; operand registers (alu_a, alu_b, alu_ctrl)=0.
REQ-036 A reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no response emitted; the first post-reset grant follows REQ-035.

Verification
REQ-037 Single request: req_valid=01, a=0x0035, b=0x0040, ctrl=2 (OR), rsp_ready=1 -> req_ready=01 in cycle N; rsp_valid=1 in N+2 with rsp_id=0, rsp_s=0x0075, rsp_zero=0.
REQ-038 Tie after reset: both valid, req0 ctrl=2 a=0x5555 b=0xAAAA; req1 ctrl=2 a=0 b=0 -> req0 served first (rsp_s=0xFFFF), then req1 (rsp_s=0, rsp_zero=1, rsp_id=1).
REQ-039 Fairness: both requesters held valid for 6 grants -> grant order 0,1,0,1,0,1; no requester granted twice in a row.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=00 throughout; rsp_ready=1 -> IDLE the next cycle, and a pending request is granted that cycle.
REQ-041 Reset mid-op: assert rst during EXEC -> next cycle rsp_valid=0, all outputs 0, no response ever appears for the dropped request.
REQ-042 Flag pass-through: the ALU model forces alu_overflow=1 and alu_s=0x8000 -> rsp_overflow=1, rsp_s=0x8000.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one ALU between two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [2*DATA_W-1:0] i_req_a,
  input  logic [2*DATA_W-1:0] i_req_b,
  input  logic [7:0]          i_req_ctrl,
  output logic [DATA_W-1:0]   o_alu_a,
  output logic [DATA_W-1:0]   o_alu_b,
  output logic [3:0]          o_alu_ctrl,
  input  logic [DATA_W-1:0]   i_alu_s,
  input  logic                i_alu_zero,
  input  logic                i_alu_overflow,
  output logic                o_rsp_valid,
  output logic                o_rsp_id,
  output logic [DATA_W-1:0]   o_rsp_s,
  output logic                o_rsp_zero,
  output logic                o_rsp_overflow,
  input  logic                i_rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                w_grant_vld;
  logic                w_grant_id;
  logic                w_take;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [3:0]          w_sel_ctrl;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [3:0]          r_op_ctrl;
  logic                r_op_id;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_s;
  logic                r_rsp_zero;
  logic                r_rsp_overflow;

  // On a tie the requester that did not win last time is preferred.
  always_comb begin
    w_grant_vld = |i_req_valid;
    w_grant_id  = 1'b0;
    case (i_req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last_grant;
      default: w_grant_id = 1'b0;
    endcase
  end

  assign w_sel_a    = w_grant_id ? i_req_a[2*DATA_W-1:DATA_W] : i_req_a[DATA_W-1:0];
  assign w_sel_b    = w_grant_id ? i_req_b[2*DATA_W-1:DATA_W] : i_req_b[DATA_W-1:0];
  assign w_sel_ctrl = w_grant_id ? i_req_ctrl[7:4] : i_req_ctrl[3:0];

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 2'b00;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld && !rst) begin
          w_take      = 1'b1;
          o_req_ready = w_grant_id ? 2'b10 : 2'b01;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_op_ctrl      <= '0;
      r_op_id        <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_s        <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_op_a       <= w_sel_a;
        r_op_b       <= w_sel_b;
        r_op_ctrl    <= w_sel_ctrl;
        r_op_id      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_id       <= r_op_id;
        r_rsp_s        <= i_alu_s;
        r_rsp_zero     <= i_alu_zero;
        r_rsp_overflow <= i_alu_overflow;
      end
      if ((r_state == S_RESP) && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign o_alu_a        = r_op_a;
  assign o_alu_b        = r_op_b;
  assign o_alu_ctrl     = r_op_ctrl;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_id       = r_rsp_id;
  assign o_rsp_s        = r_rsp_s;
  assign o_rsp_zero     = r_rsp_zero;
  assign o_rsp_overflow = r_rsp_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed vector bench for alu_arbiter with a small ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_ctrl;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_s;
  logic        alu_zero;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_s;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_ready;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.DATA_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .i_req_ctrl     (req_ctrl),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_ctrl     (alu_ctrl),
    .i_alu_s        (alu_s),
    .i_alu_zero     (alu_zero),
    .i_alu_overflow (alu_overflow),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_id       (rsp_id),
    .o_rsp_s        (rsp_s),
    .o_rsp_zero     (rsp_zero),
    .o_rsp_overflow (rsp_overflow),
    .i_rsp_ready    (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 0 AND, 2 OR, 3 signed ADD with overflow, others 0.
  always_comb begin
    alu_s        = 16'h0000;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'd0: alu_s = alu_a & alu_b;
      4'd2: alu_s = alu_a | alu_b;
      4'd3: begin
        alu_s        = alu_a + alu_b;
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
      end
      default: alu_s = 16'h0000;
    endcase
    alu_zero = (alu_s == 16'h0000);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] a0, b0;
    logic [3:0]  c0;
    logic [15:0] a1, b1;
    logic [3:0]  c1;
    logic [1:0]  grant;
    logic        id;
    logic [15:0] s;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b11, 16'h5555, 16'hAAAA, 4'd2, 16'h0000, 16'h0000, 4'd2, 2'b01, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 16'h5555, 16'hAAAA, 4'd2, 16'h0000, 16'h0000, 4'd2, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 16'h0035, 16'h0040, 4'd2, 16'h1111, 16'h2222, 4'd0, 2'b01, 1'b0, 16'h0075, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 16'h0001, 16'h0001, 4'd3, 16'h7FFF, 16'h0001, 4'd3, 2'b10, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{2'b01, 16'hF0F0, 16'h0FF0, 4'd0, 16'hFFFF, 16'hFFFF, 4'd2, 2'b01, 1'b0, 16'h00F0, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 16'h0000, 16'h0000, 4'd2, 16'h0001, 16'hFFFF, 4'd3, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset with requests pending: nothing may be granted.
    rst = 1'b1; req_valid = 2'b11; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
    req_ctrl = 8'h22; rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_s", 32'(rsp_s), 32'h0);
    chk("rst_rsp_flags", 32'({rsp_zero, rsp_overflow}), 32'h0);
    chk("rst_alu_ops", {alu_a, alu_b}, 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;

    for (int i = 0; i < 6; i++) begin
      req_valid = vecs[i].valid;
      req_a     = {vecs[i].a1, vecs[i].a0};
      req_b     = {vecs[i].b1, vecs[i].b0};
      req_ctrl  = {vecs[i].c1, vecs[i].c0};
      rsp_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(req_ready), 32'(vecs[i].grant));
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_exec_valid", i), 32'(rsp_valid), 32'h0);
      chk($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].grant == 2'b10 ? vecs[i].a1 : vecs[i].a0));
      chk($sformatf("v%0d_exec_ready", i), 32'(req_ready), 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].id));
      chk($sformatf("v%0d_rsp_s", i), 32'(rsp_s), 32'(vecs[i].s));
      chk($sformatf("v%0d_rsp_flags", i), 32'({rsp_zero, rsp_overflow}), 32'({vecs[i].z, vecs[i].v}));
      @(posedge clk); #1;
    end

    // Fairness: both held valid for six grants.
    begin
      int gcnt;
      logic [1:0] exp_g;
      gcnt = 0; exp_g = 2'b01;
      req_valid = 2'b11; rsp_ready = 1'b1;
      req_a = 32'h0002_0001; req_b = 32'h0000_0000; req_ctrl = 8'h22;
      for (int c = 0; c < 60 && gcnt < 6; c++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          chk("fair_grant", 32'(req_ready), 32'(exp_g));
          exp_g = {exp_g[0], exp_g[1]};
          gcnt++;
        end
        @(posedge clk); #1;
      end
      if (gcnt < 6) chk("fair_timeout", gcnt, 6);
      req_valid = 2'b00;
      @(posedge clk); @(posedge clk); #1;
    end

    // Backpressure with a request from requester 1 waiting.
    req_valid = 2'b01; rsp_ready = 1'b0;
    req_a = 32'h0F00_1234; req_b = 32'h000F_00FF; req_ctrl = 8'h22;
    @(negedge clk);
    chk("bp_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp_exec_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_s", 32'(rsp_s), 32'h12FF);
      chk("bp_hold_id", 32'(rsp_id), 32'h0);
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", 32'(rsp_valid), 32'h1);
    chk("bp_accept_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_valid", 32'(rsp_valid), 32'h0);
    chk("bp_pending_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("bp_rsp1_id", 32'(rsp_id), 32'h1);
    chk("bp_rsp1_s", 32'(rsp_s), 32'h0F0F);
    @(posedge clk); #1;

    // Reset while the operation is in EXEC.
    req_valid = 2'b01; rsp_ready = 1'b1;
    req_a = 32'h0000_ABCD; req_b = 32'h0000_0000; req_ctrl = 8'h02;
    @(negedge clk);
    chk("mr_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    chk("mr_exec_alu_a", 32'(alu_a), 32'hABCD);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mr_alu", {alu_a, alu_b}, 32'h0);
    chk("mr_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("mr_rsp_s", 32'(rsp_s), 32'h0);
    chk("mr_rsp_id", 32'(rsp_id), 32'h0);
    chk("mr_req_ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("mr_tie_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
